// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds datapath widths, the PC step, the default reset PC and the
// {pc, instruction} payload carried through the instruction buffer.
package if_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSN_W  = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } if_entry_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(PC_STEP - 1);
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Instruction buffer: synchronous DEPTH-entry FIFO of {pc, instruction}.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             empties the buffer; overrides same-cycle push/pop
//   push, push_entry  write one entry at the tail
//   pop               release the head entry
//   head_entry        current head (reset value {RESET_PC, 0})
//   count, empty      occupancy
module if_fifo
    import if_stage_pkg::*;
#(
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int unsigned    CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  if_entry_t        push_entry,
    input  logic             pop,
    output if_entry_t        head_entry,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if_entry_t        mem_q [DEPTH];
    if_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: flush wins, otherwise independent push and pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && !flush && (count_q != '0);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '{pc: RESET_PC, insn: '0};
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign empty      = (count_q == '0);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word-aligned fetches, tags in-order
// responses with their PC, buffers them and hands them to decode.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid, imem_rsp_data    in-order response channel
//   redirect_valid, redirect_pc      single-cycle branch/jump redirect
//   id_valid/ready, id_instruction,
//   id_pc                            decode handoff
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INSN_W-1:0] id_instruction,
    output logic [XLEN-1:0]   id_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;
    logic             req_fire, rsp_accept, push, pop;
    logic [XLEN-1:0]  redirect_base;
    if_entry_t        push_entry, head;

    // Request credit, response bookkeeping and redirect handling.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        redirect_base = align_pc(redirect_pc);

        // Outstanding requests plus buffered words never exceed DEPTH,
        // so every response is guaranteed a free buffer slot.
        imem_req_valid = !rst && !redirect_valid &&
                         ((SUM_W'(outstanding_q) + SUM_W'(buf_count)) < SUM_W'(DEPTH));
        req_fire   = imem_req_valid && imem_req_ready;
        rsp_accept = imem_rsp_valid && (outstanding_q != '0);
        push       = rsp_accept && !redirect_valid && (discard_q == '0);
        pop        = !buf_empty && id_ready;
        push_entry = '{pc: rsp_pc_q, insn: imem_rsp_data};

        case ({req_fire, rsp_accept})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            discard_d  = outstanding_q - CNT_W'(rsp_accept);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (rsp_accept) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    if_fifo #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head),
        .count      (buf_count),
        .empty      (buf_empty)
    );

    assign imem_addr      = fetch_pc_q;
    assign id_valid       = !buf_empty;
    assign id_instruction = head.insn;
    assign id_pc          = head.pc;

endmodule
